// File: rtl/phy_pkg.sv
// Shared PHY definitions for the serial lane (comma byte, byte width, tx states).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package phy_pkg;

    localparam int BYTE_W = 8;

    // Idle/training symbol; the receive deserializer locks on the same value.
    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Link-layer to serializer bundle: byte handshake, enable, serial line and status.
// Latency: n/a (wiring only).
// Backpressure: ready_out gates acceptance; upstream holds data_in while waiting.
interface paralelo_serial_tx_if;
    import phy_pkg::*;

    logic              tx_enable;
    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              data_out;
    logic              active;
    logic              comma_err;

    // Link-layer side
    modport master (
        output tx_enable, data_in, valid_in,
        input  ready_out, data_out, active, comma_err
    );

    // Serializer side
    modport slave (
        input  tx_enable, data_in, valid_in,
        output ready_out, data_out, active, comma_err
    );

endinterface

// File: rtl/paralelo_serial_tx.sv
// MSB-first byte serializer with comma idle fill and post-reset/re-enable comma training.
// Latency: accepted byte's first bit appears on data_out 1 cycle after the handshake.
// Backpressure: ready_out only at byte boundaries while ACTIVE and enabled; otherwise data_in waits.
module paralelo_serial_tx #(
    parameter logic [7:0] COMMA       = phy_pkg::COMMA,
    parameter int         SYNC_COMMAS = 4
) (
    input logic                 clk_32f,
    input logic                 reset,
    paralelo_serial_tx_if.slave lnk
);
    import phy_pkg::*;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMMAS - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [3:0]        sync_cnt;
    logic [3:0]        sync_cnt_nxt;
    logic [BYTE_W-1:0] sr;
    logic [2:0]        bit_cnt;
    logic              boundary;
    logic              accept;
    logic              comma_err_q;

    assign boundary      = (bit_cnt == 3'd7);
    assign lnk.ready_out = (state == ACTIVE) && boundary && lnk.tx_enable;
    assign accept        = lnk.valid_in && lnk.ready_out;
    assign lnk.data_out  = sr[7];
    assign lnk.active    = (state == ACTIVE);
    assign lnk.comma_err = comma_err_q;

    // Shifter: shift every bit time, reload a whole byte (payload or comma) at the boundary.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr      <= COMMA;
            bit_cnt <= 3'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (boundary) begin
                sr <= accept ? lnk.data_in : COMMA;
            end else begin
                sr <= {sr[6:0], 1'b0};
            end
        end
    end

    // Flag a payload byte that aliases the comma; it is still sent unchanged.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            comma_err_q <= 1'b0;
        end else begin
            comma_err_q <= accept && (lnk.data_in == COMMA);
        end
    end

    // Training FSM state register.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state    <= SYNC;
            sync_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
        end
    end

    // Training FSM next state: count comma boundaries in SYNC, fall back on disable.
    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        if (boundary) begin
            if (state == SYNC) begin
                if (!lnk.tx_enable) begin
                    sync_cnt_nxt = 4'd0;
                end else begin
                    sync_cnt_nxt = sync_cnt + 4'd1;
                    if (sync_cnt == SYNC_LAST) begin
                        state_nxt = ACTIVE;
                    end
                end
            end else if (!lnk.tx_enable) begin
                state_nxt    = SYNC;
                sync_cnt_nxt = 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: slot-level reference model checked every cycle plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_paralelo_serial_tx;
    import phy_pkg::*;

    localparam int SYNC_COMMAS = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    paralelo_serial_tx_if lnk ();

    paralelo_serial_tx #(
        .COMMA      (COMMA),
        .SYNC_COMMAS(SYNC_COMMAS)
    ) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .lnk    (lnk)
    );

    always #5 clk_32f = ~clk_32f;

    int checks = 0;
    int errors = 0;

    // Reference model: byte slots of 8 bit times since reset release
    int         m_cyc;
    logic [7:0] m_byte;
    bit         m_trained;
    int         m_train;
    bit         m_err;
    logic [2:0] ph;
    bit         exp_rdy;

    // Observations
    logic [7:0] rx_log[$];
    logic [7:0] shreg;
    int         first_active = -1;
    int         first_ready  = -1;
    int         rdy_pulses   = 0;
    int         err_pulses   = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare process: every bit time, DUT outputs against the slot model.
    always @(negedge clk_32f) begin
        if (reset) begin
            m_cyc        = 0;
            m_byte       = COMMA;
            m_trained    = 1'b0;
            m_train      = 0;
            m_err        = 1'b0;
            first_active = -1;
            first_ready  = -1;
            rx_log.delete();
            check_bit("rst_data_out", lnk.data_out, 1'b1);
            check_bit("rst_ready", lnk.ready_out, 1'b0);
            check_bit("rst_active", lnk.active, 1'b0);
            check_bit("rst_comma_err", lnk.comma_err, 1'b0);
        end else begin
            ph      = m_cyc[2:0];
            exp_rdy = m_trained && (ph == 3'd7) && lnk.tx_enable;
            check_bit("data_out", lnk.data_out, m_byte[3'd7 - ph]);
            check_bit("ready_out", lnk.ready_out, exp_rdy);
            check_bit("active", lnk.active, m_trained);
            check_bit("comma_err", lnk.comma_err, m_err && (ph == 3'd0));
            shreg = {shreg[6:0], lnk.data_out};
            if (lnk.active && first_active < 0) first_active = m_cyc;
            if (lnk.ready_out && first_ready < 0) first_ready = m_cyc;
            if (lnk.ready_out) rdy_pulses++;
            if (lnk.comma_err) err_pulses++;
            if (ph == 3'd7) begin
                rx_log.push_back(shreg);
                m_err = 1'b0;
                if (exp_rdy && lnk.valid_in) begin
                    m_byte = lnk.data_in;
                    m_err  = (lnk.data_in == COMMA);
                end else begin
                    m_byte = COMMA;
                end
                if (!m_trained) begin
                    if (lnk.tx_enable) begin
                        m_train++;
                        if (m_train == SYNC_COMMAS) m_trained = 1'b1;
                    end else begin
                        m_train = 0;
                    end
                end else if (!lnk.tx_enable) begin
                    m_trained = 1'b0;
                    m_train   = 0;
                end
            end
            m_cyc++;
        end
    end

    // Advance to just after the posedge that starts a cycle of the given bit phase.
    task automatic goto_phase(input int p);
        do begin
            @(posedge clk_32f);
            #1;
        end while (m_cyc % 8 != p);
    endtask

    // Advance to just after the posedge that starts slot n (slots 0..n-1 logged).
    task automatic wait_slot_end(input int n);
        int guard = 0;
        while (m_cyc < n * 8 && guard < 2000) begin
            @(posedge clk_32f);
            #1;
            guard++;
        end
        if (m_cyc < n * 8) begin
            checks++;
            errors++;
            $display("FAIL wait_slot timeout: at cycle %0d, needed %0d", m_cyc, n * 8);
        end
    endtask

    // Training burst after reset: 10 comma bytes, active at cycle 32, first ready at cycle 39.
    task automatic run_training(input string tag);
        repeat (80) @(negedge clk_32f);
        #1;
        check_int({tag, "_bytes"}, rx_log.size(), 10);
        for (int k = 0; k < 10; k++) begin
            check_byte({tag, "_comma"}, rx_log[k], 8'hBC);
        end
        check_int({tag, "_first_active"}, first_active, 32);
        check_int({tag, "_first_ready"}, first_ready, 39);
    endtask

    initial begin
        int t;
        int r0;
        int e0;
        lnk.tx_enable = 1'b1;
        lnk.valid_in  = 1'b0;
        lnk.data_in   = 8'h00;
        shreg         = 8'h00;
        repeat (3) @(posedge clk_32f);
        #1 reset = 1'b0;

        // 1: training burst after reset
        run_training("t1");

        // 2: continuous payload A5
        goto_phase(0);
        t = m_cyc / 8;
        lnk.data_in  = 8'hA5;
        lnk.valid_in = 1'b1;
        r0 = rdy_pulses;
        wait_slot_end(t + 4);
        check_byte("t2_lead", rx_log[t], 8'hBC);
        for (int k = 1; k <= 3; k++) check_byte("t2_payload", rx_log[t + k], 8'hA5);
        check_int("t2_ready_pulses", rdy_pulses - r0, 4);

        // 3: single byte 3C between commas
        t = t + 4;
        lnk.data_in = 8'h3C;
        wait_slot_end(t + 1);
        lnk.valid_in = 1'b0;
        wait_slot_end(t + 4);
        check_byte("t3_prev", rx_log[t], 8'hA5);
        check_byte("t3_single", rx_log[t + 1], 8'h3C);
        check_byte("t3_idle0", rx_log[t + 2], 8'hBC);
        check_byte("t3_idle1", rx_log[t + 3], 8'hBC);

        // 4: payload equal to comma raises a one-cycle comma_err
        t = t + 4;
        lnk.data_in  = 8'hBC;
        lnk.valid_in = 1'b1;
        e0 = err_pulses;
        wait_slot_end(t + 1);
        lnk.valid_in = 1'b0;
        wait_slot_end(t + 3);
        check_byte("t4_sent", rx_log[t + 1], 8'hBC);
        check_int("t4_err_pulses", err_pulses - e0, 1);

        // 5: disable mid-byte of F0, byte completes, then retraining
        t = t + 3;
        lnk.data_in  = 8'hF0;
        lnk.valid_in = 1'b1;
        wait_slot_end(t + 1);
        r0 = rdy_pulses;
        goto_phase(3);
        lnk.tx_enable = 1'b0;
        wait_slot_end(t + 2);
        check_bit("t5_inactive", lnk.active, 1'b0);
        lnk.tx_enable = 1'b1;
        wait_slot_end(t + 6);
        check_int("t5_no_ready", rdy_pulses - r0, 0);
        wait_slot_end(t + 7);
        lnk.valid_in = 1'b0;
        wait_slot_end(t + 9);
        check_byte("t5_inflight", rx_log[t + 1], 8'hF0);
        for (int k = 2; k <= 6; k++) check_byte("t5_retrain", rx_log[t + k], 8'hBC);
        check_byte("t5_resume", rx_log[t + 7], 8'hF0);
        check_byte("t5_idle", rx_log[t + 8], 8'hBC);

        // 6: reset in the middle of payload 0F
        t = t + 9;
        lnk.data_in  = 8'h0F;
        lnk.valid_in = 1'b1;
        wait_slot_end(t + 1);
        goto_phase(2);
        check_bit("t6_pre_bit", lnk.data_out, 1'b0);
        reset        = 1'b1;
        lnk.valid_in = 1'b0;
        #1;
        check_bit("t6_async_data", lnk.data_out, 1'b1);
        check_bit("t6_async_ready", lnk.ready_out, 1'b0);
        check_bit("t6_async_active", lnk.active, 1'b0);
        repeat (3) @(posedge clk_32f);
        #1 reset = 1'b0;
        run_training("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
